// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: state encoding and default timing constants
// shared by the pixel-clock PLL sequencing controller.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } pll_ctrl_state_t;

   localparam int PLL_RST_HOLD_DEF     = 16;
   localparam int PLL_LOCK_STABLE_DEF  = 1024;
   localparam int PLL_LOCK_TIMEOUT_DEF = 50000;
   localparam int PLL_MAX_RETRIES_DEF  = 3;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: one-bit two-flop synchroniser for asynchronous
// level inputs; synchronous active-high reset clears both stages.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset sequencing, lock qualification and retry.
// Define PLL_LOCK_CTRL_LOSS_CNT_EN to build the lock-loss counter.
module pll_lock_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int RST_HOLD_CYCLES     = PLL_RST_HOLD_DEF,
   parameter int LOCK_STABLE_CYCLES  = PLL_LOCK_STABLE_DEF,
   parameter int LOCK_TIMEOUT_CYCLES = PLL_LOCK_TIMEOUT_DEF,
   parameter int MAX_RETRIES         = PLL_MAX_RETRIES_DEF
) (
   input  logic                               refclk,
   input  logic                               rst,
   input  logic                               pll_locked,
   input  logic                               relock_req,
   output logic                               pll_rst,
   output logic                               sys_rst,
   output logic                               ready,
   output logic                               fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
   output logic [7:0]                         lock_loss_cnt
);

   localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
   localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(MAX_RETRIES + 1);

   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
   localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

   pll_ctrl_state_t r_state;
   pll_ctrl_state_t w_state_nx;
   logic [HW-1:0]   r_hold_cnt;
   logic [HW-1:0]   w_hold_nx;
   logic [SW-1:0]   r_stab_cnt;
   logic [SW-1:0]   w_stab_nx;
   logic [TW-1:0]   r_to_cnt;
   logic [TW-1:0]   w_to_nx;
   logic [RW-1:0]   r_retry_cnt;
   logic [RW-1:0]   w_retry_nx;
   logic            r_pll_rst;
   logic            r_sys_rst;
   logic            r_ready;
   logic            r_fault;
   logic            w_locked_s;

   sync_2ff u_lock_sync (
      .i_clk (refclk),
      .i_rst (rst),
      .i_d   (pll_locked),
      .o_q   (w_locked_s)
   );

   // Timeout budget survives STABLE->WAIT_LOCK bounces within one attempt.
   always_comb begin
      w_state_nx = r_state;
      w_retry_nx = r_retry_cnt;
      w_to_nx    = ((r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE))
                   ? r_to_cnt : '0;
      unique case (r_state)
         ST_RESET: begin
            if (r_hold_cnt == HOLD_LAST) w_state_nx = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (w_locked_s) begin
               w_state_nx = ST_STABLE;
            end else if (r_to_cnt == TO_LAST) begin
               w_retry_nx = r_retry_cnt + 1'b1;
               w_state_nx = (w_retry_nx == RETRY_MAX) ? ST_FAULT : ST_RESET;
            end else begin
               w_to_nx = r_to_cnt + 1'b1;
            end
         end
         ST_STABLE: begin
            if (!w_locked_s) begin
               w_state_nx = ST_WAIT_LOCK;
            end else if (r_stab_cnt == STAB_LAST) begin
               w_state_nx = ST_RUN;
               w_retry_nx = '0;
            end
         end
         ST_RUN: begin
            if (!w_locked_s) w_state_nx = ST_RESET;
         end
         ST_FAULT: w_state_nx = ST_FAULT;
         default:  w_state_nx = ST_RESET;
      endcase
      if (relock_req) begin
         w_state_nx = ST_RESET;
         w_retry_nx = '0;
      end
      w_hold_nx = '0;
      if ((r_state == ST_RESET) && (w_state_nx == ST_RESET) && !relock_req)
         w_hold_nx = r_hold_cnt + 1'b1;
      w_stab_nx = '0;
      if ((r_state == ST_STABLE) && (w_state_nx == ST_STABLE))
         w_stab_nx = r_stab_cnt + 1'b1;
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state     <= ST_RESET;
         r_hold_cnt  <= '0;
         r_stab_cnt  <= '0;
         r_to_cnt    <= '0;
         r_retry_cnt <= '0;
         r_pll_rst   <= 1'b1;
         r_sys_rst   <= 1'b1;
         r_ready     <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_hold_cnt  <= w_hold_nx;
         r_stab_cnt  <= w_stab_nx;
         r_to_cnt    <= w_to_nx;
         r_retry_cnt <= w_retry_nx;
         r_pll_rst   <= (w_state_nx == ST_RESET) || (w_state_nx == ST_FAULT);
         r_sys_rst   <= (w_state_nx != ST_RUN);
         r_ready     <= (w_state_nx == ST_RUN);
         r_fault     <= (w_state_nx == ST_FAULT);
      end
   end

`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
   logic       w_loss_ev;
   logic [7:0] r_loss_cnt;

   // Counted even when a relock request wins the transition.
   assign w_loss_ev = (r_state == ST_RUN) && !w_locked_s;

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_loss_cnt <= '0;
      end else if (w_loss_ev && (r_loss_cnt != 8'hFF)) begin
         r_loss_cnt <= r_loss_cnt + 8'd1;
      end
   end

   assign lock_loss_cnt = r_loss_cnt;
`else
   assign lock_loss_cnt = 8'd0;
`endif

   assign pll_rst   = r_pll_rst;
   assign sys_rst   = r_sys_rst;
   assign ready     = r_ready;
   assign fault     = r_fault;
   assign retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed self-checking bench for pll_lock_ctrl
// (hold 4, stable 8, timeout 32, retries 2).
module tb_pll_lock_ctrl;

   logic       refclk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fault;
   logic [1:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
   localparam logic LOSS_EN = 1'b1;
`else
   localparam logic LOSS_EN = 1'b0;
`endif

   pll_lock_ctrl #(
      .RST_HOLD_CYCLES     (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (32),
      .MAX_RETRIES         (2)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .pll_locked    (pll_locked),
      .relock_req    (relock_req),
      .pll_rst       (pll_rst),
      .sys_rst       (sys_rst),
      .ready         (ready),
      .fault         (fault),
      .retry_cnt     (retry_cnt),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #5 refclk = ~refclk;

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      tick(3);
      n_checks++;
      if (pll_rst !== 1'b1) begin
         n_fail++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst);
      end
      n_checks++;
      if (sys_rst !== 1'b1) begin
         n_fail++; $display("FAIL reset_sys_rst: got %b want 1", sys_rst);
      end
      n_checks++;
      if (ready !== 1'b0 || fault !== 1'b0) begin
         n_fail++; $display("FAIL reset_rdy_flt: got %b%b want 00", ready, fault);
      end
      n_checks++;
      if (retry_cnt !== 2'd0 || lock_loss_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_cnts: got %0d/%0d want 0/0", retry_cnt, lock_loss_cnt);
      end
   endtask

   task automatic test_lock();
      int hi;
      int n;
      rst = 1'b0;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (!pll_rst) break;
         hi++;
         tick(1);
      end
      n_checks++;
      if (hi != 4) begin
         n_fail++; $display("FAIL lock_pll_rst_len: got %0d want 4", hi);
      end
      tick(6);
      pll_locked = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         n++;
         if (!sys_rst) break;
      end
      n_checks++;
      if (n != 11 || ready !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_release: got %0d cycles ready=%b want 11 ready=1", n, ready);
      end
      n_checks++;
      if (retry_cnt !== 2'd0 || pll_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL lock_run_state: got retry=%0d pll_rst=%b want 0/0", retry_cnt, pll_rst);
      end
   endtask

   task automatic test_timeout();
      rst = 1'b1;
      pll_locked = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(35);
      n_checks++;
      if (pll_rst !== 1'b0 || retry_cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL to_before_1: got pll_rst=%b retry=%0d want 0/0", pll_rst, retry_cnt);
      end
      tick(1);
      n_checks++;
      if (pll_rst !== 1'b1 || retry_cnt !== 2'd1 || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL to_first: got pll_rst=%b retry=%0d fault=%b want 1/1/0",
                  pll_rst, retry_cnt, fault);
      end
      tick(4);
      n_checks++;
      if (pll_rst !== 1'b0) begin
         n_fail++; $display("FAIL to_second_wait: got pll_rst=%b want 0", pll_rst);
      end
      tick(31);
      n_checks++;
      if (fault !== 1'b0) begin
         n_fail++; $display("FAIL to_before_2: got fault=%b want 0", fault);
      end
      tick(1);
      n_checks++;
      if (fault !== 1'b1 || retry_cnt !== 2'd2 || pll_rst !== 1'b1 || sys_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL to_fault: got fault=%b retry=%0d pll_rst=%b sys_rst=%b want 1/2/1/1",
                  fault, retry_cnt, pll_rst, sys_rst);
      end
      tick(8);
      n_checks++;
      if (fault !== 1'b1) begin
         n_fail++; $display("FAIL to_fault_hold: got fault=%b want 1", fault);
      end
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
      n_checks++;
      if (fault !== 1'b0 || retry_cnt !== 2'd0 || pll_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL to_relock: got fault=%b retry=%0d pll_rst=%b want 0/0/1",
                  fault, retry_cnt, pll_rst);
      end
      tick(3);
      n_checks++;
      if (pll_rst !== 1'b1) begin
         n_fail++; $display("FAIL to_relock_hold: got pll_rst=%b want 1", pll_rst);
      end
      tick(1);
      n_checks++;
      if (pll_rst !== 1'b0) begin
         n_fail++; $display("FAIL to_relock_end: got pll_rst=%b want 0", pll_rst);
      end
   endtask

   task automatic test_glitch();
      pll_locked = 1'b1;
      tick(6);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(2);
      n_checks++;
      if (ready !== 1'b0 || sys_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_drop: got ready=%b sys_rst=%b want 0/1", ready, sys_rst);
      end
      tick(2);
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL glitch_no_early_run: got ready=%b want 0", ready);
      end
      tick(6);
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL glitch_pre_run: got ready=%b want 0", ready);
      end
      tick(1);
      n_checks++;
      if (ready !== 1'b1 || sys_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_run: got ready=%b sys_rst=%b want 1/0", ready, sys_rst);
      end
   endtask

   task automatic test_loss();
      pll_locked = 1'b0;
      tick(2);
      n_checks++;
      if (ready !== 1'b1 || pll_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL loss_early: got ready=%b pll_rst=%b want 1/0", ready, pll_rst);
      end
      tick(1);
      n_checks++;
      if (pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL loss_resp: got pll_rst=%b sys_rst=%b ready=%b want 1/1/0",
                  pll_rst, sys_rst, ready);
      end
      n_checks++;
      if (lock_loss_cnt !== (LOSS_EN ? 8'd1 : 8'd0) || retry_cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL loss_cnt: got loss=%0d retry=%0d want %0d/0",
                  lock_loss_cnt, retry_cnt, LOSS_EN ? 1 : 0);
      end
      pll_locked = 1'b1;
      tick(12);
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL loss_pre_rerun: got ready=%b want 0", ready);
      end
      tick(1);
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++; $display("FAIL loss_rerun: got ready=%b want 1", ready);
      end
   endtask

   task automatic test_relock_loss();
      logic to;
      int   w;
      pll_locked = 1'b0;
      tick(2);
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
      n_checks++;
      if (pll_rst !== 1'b1 || ready !== 1'b0 || retry_cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL rl_state: got pll_rst=%b ready=%b retry=%0d want 1/0/0",
                  pll_rst, ready, retry_cnt);
      end
      n_checks++;
      if (lock_loss_cnt !== (LOSS_EN ? 8'd2 : 8'd0)) begin
         n_fail++;
         $display("FAIL rl_loss_cnt: got %0d want %0d", lock_loss_cnt, LOSS_EN ? 2 : 0);
      end
      to = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (to) break;
         pll_locked = 1'b1;
         w = 0;
         while (!ready && w < 40) begin tick(1); w++; end
         if (!ready) to = 1'b1;
         pll_locked = 1'b0;
         w = 0;
         while (ready && w < 10) begin tick(1); w++; end
         if (ready) to = 1'b1;
      end
      n_checks++;
      if (to) begin
         n_fail++; $display("FAIL rl_loop_timeout: got timeout=1 want 0");
      end
      n_checks++;
      if (lock_loss_cnt !== (LOSS_EN ? 8'd255 : 8'd0)) begin
         n_fail++;
         $display("FAIL rl_saturate: got %0d want %0d", lock_loss_cnt, LOSS_EN ? 255 : 0);
      end
   endtask

   task automatic test_mid_rst();
      int w;
      int hi;
      pll_locked = 1'b1;
      w = 0;
      while (pll_rst && w < 20) begin tick(1); w++; end
      tick(2);
      n_checks++;
      if (ready !== 1'b0 || pll_rst !== 1'b0 || sys_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL mr_in_stable: got ready=%b pll_rst=%b sys_rst=%b want 0/0/1",
                  ready, pll_rst, sys_rst);
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      n_checks++;
      if (pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0 || fault !== 1'b0
          || retry_cnt !== 2'd0 || lock_loss_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL mr_reset_vals: got %b%b%b%b retry=%0d loss=%0d want 1100 0 0",
                  pll_rst, sys_rst, ready, fault, retry_cnt, lock_loss_cnt);
      end
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (!pll_rst) break;
         hi++;
         tick(1);
      end
      n_checks++;
      if (hi != 4) begin
         n_fail++; $display("FAIL mr_pll_rst_len: got %0d want 4", hi);
      end
      tick(8);
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL mr_pre_run: got ready=%b want 0", ready);
      end
      tick(1);
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++; $display("FAIL mr_run: got ready=%b want 1", ready);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_timeout();
      test_glitch();
      test_loss();
      test_relock_loss();
      test_mid_rst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
